sw_serializer: RTL and testbench

SW_SERIALIZER -- requirements
Module: sw_serializer

---
 rtl/sw_serializer.sv | 134 +++++++++++++
 tb/tb_sw_serializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_serializer.sv
// sw_serializer: captures a parallel switch word and shifts it out MSB first
// under a valid/ready handshake, followed by a programmable idle gap.
`default_nettype none

module sw_serializer #(
  parameter int WIDTH = 10,
  parameter int GAP   = 2
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             load,
  input  logic             auto_mode,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t             state, state_n;
  // Holds the bits not yet presented, MSB-aligned; the presented bit lives in ser_out.
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [WIDTH-1:0]   sw_last, sw_last_n;
  logic [3:0]         gap_cnt, gap_cnt_n;
  logic [3:0]         bit_cnt_n;
  logic               ser_out_n, ser_valid_n, busy_n, done_n;
  logic               start, xfer;

  assign start = load | (auto_mode & (SW != sw_last));
  assign xfer  = ser_valid & ser_ready;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      sw_last   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      sw_last   <= sw_last_n;
      gap_cnt   <= gap_cnt_n;
      bit_cnt   <= bit_cnt_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    sw_last_n   = sw_last;
    gap_cnt_n   = gap_cnt;
    bit_cnt_n   = bit_cnt;
    ser_out_n   = ser_out;
    ser_valid_n = ser_valid;
    busy_n      = busy;
    done_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n     = S_SHIFT;
          shreg_n     = {SW[WIDTH-2:0], 1'b0};
          sw_last_n   = SW;
          bit_cnt_n   = 4'd0;
          ser_out_n   = SW[WIDTH-1];
          ser_valid_n = 1'b1;
          busy_n      = 1'b1;
        end
      end

      S_SHIFT: begin
        if (xfer) begin
          if (bit_cnt == LAST_IDX) begin
            done_n      = 1'b1;
            ser_valid_n = 1'b0;
            ser_out_n   = 1'b0;
            bit_cnt_n   = 4'd0;
            if (GAP > 0) begin
              state_n   = S_GAP;
              gap_cnt_n = GAP_LOAD;
            end else begin
              state_n   = S_IDLE;
              busy_n    = 1'b0;
            end
          end else begin
            shreg_n   = {shreg[WIDTH-2:0], 1'b0};
            ser_out_n = shreg[WIDTH-1];
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end

      S_GAP: begin
        // The done cycle is the first gap cycle, so the gap spans exactly GAP cycles.
        if (gap_cnt == 4'd0) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end

      default: begin
        state_n     = S_IDLE;
        ser_valid_n = 1'b0;
        ser_out_n   = 1'b0;
        busy_n      = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sw_serializer.sv
// Bench for sw_serializer: a GAP=2 and a GAP=0 instance share stimulus and are
// checked every cycle against a frame-level reference model.
`default_nettype none

module tb_sw_serializer;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] sw = '0;
  logic         load = 1'b0, auto_mode = 1'b0, ready = 1'b1;

  logic         out2, valid2, busy2, done2;
  logic [3:0]   cnt2;
  logic         out0, valid0, busy0, done0;
  logic [3:0]   cnt0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sw_serializer #(.WIDTH(W), .GAP(2)) dut_g2 (
    .CLOCK_50(clk), .Reset(rst), .SW(sw), .load(load), .auto_mode(auto_mode),
    .ser_ready(ready), .ser_out(out2), .ser_valid(valid2), .busy(busy2),
    .done(done2), .bit_cnt(cnt2)
  );

  sw_serializer #(.WIDTH(W), .GAP(0)) dut_g0 (
    .CLOCK_50(clk), .Reset(rst), .SW(sw), .load(load), .auto_mode(auto_mode),
    .ser_ready(ready), .ser_out(out0), .ser_valid(valid0), .busy(busy0),
    .done(done0), .bit_cnt(cnt0)
  );

  // Frame-level model: a frame is the captured word plus the number of bits already sent.
  typedef struct {
    logic         act;
    logic [W-1:0] word;
    int           sent;
    int           gap_left;
    logic [W-1:0] sw_last;
    logic         done;
  } model_t;

  model_t m2, m0;

  function automatic model_t model_reset();
    model_t r;
    r.act = 1'b0; r.word = '0; r.sent = 0; r.gap_left = 0; r.sw_last = '0; r.done = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input int gap, input logic ld,
                                        input logic au, input logic [W-1:0] s, input logic rdy);
    model_t n = m;
    n.done = 1'b0;
    if (m.act) begin
      if (rdy) begin
        n.sent = m.sent + 1;
        if (n.sent == W) begin
          n.act = 1'b0;
          n.sent = 0;
          n.done = 1'b1;
          n.gap_left = gap;
        end
      end
    end else if (m.gap_left > 0) begin
      n.gap_left = m.gap_left - 1;
    end else if (ld || (au && s != m.sw_last)) begin
      n.act = 1'b1;
      n.word = s;
      n.sw_last = s;
      n.sent = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string tag, input model_t m, input logic o, input logic v,
                     input logic b, input logic d, input logic [3:0] c);
    logic eo;
    eo = m.act ? m.word[W-1-m.sent] : 1'b0;
    check({tag, ".ser_out"},   {31'd0, o}, {31'd0, eo});
    check({tag, ".ser_valid"}, {31'd0, v}, {31'd0, m.act});
    check({tag, ".busy"},      {31'd0, b}, {31'd0, (m.act || m.gap_left > 0)});
    check({tag, ".done"},      {31'd0, d}, {31'd0, m.done});
    check({tag, ".bit_cnt"},   {28'd0, c}, m.act ? m.sent : 0);
  endtask

  task automatic cmp_both();
    cmp("g2", m2, out2, valid2, busy2, done2, cnt2);
    cmp("g0", m0, out0, valid0, busy0, done0, cnt0);
  endtask

  task automatic cyc(input logic ld, input logic au, input logic [W-1:0] s, input logic rdy);
    load = ld; auto_mode = au; sw = s; ready = rdy;
    @(posedge clk);
    if (!rst) begin
      m2 = model_step(m2, 2, ld, au, s, rdy);
      m0 = model_step(m0, 0, ld, au, s, rdy);
    end
    #1;
    cmp_both();
  endtask

  // Async reset: outputs must clear before any clock edge; reset then holds over an edge with load=1.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    m2 = model_reset();
    m0 = model_reset();
    cmp_both();
    cyc(1'b1, 1'b0, sw, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b, rs;
    logic ra;
    a = 10'b1010101010;
    b = 10'b1101010101;
    m2 = model_reset();
    m0 = model_reset();

    #1 rst = 1'b1;
    #1 cmp_both();
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, continuous ready, then gap and idle.
    cyc(1'b1, 1'b0, a, 1'b1);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, a, 1'b1);
    check("frame_a_done_ok", {31'd0, busy2}, 32'd0);

    // Three-cycle stall at bit 4.
    cyc(1'b1, 1'b0, a, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, a, 1'b1);
    check("stall_cnt4", {28'd0, cnt2}, 32'd4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, a, 1'b0);
    check("stall_bit", {31'd0, out2}, 32'd1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, a, 1'b1);

    // Load with a new word while busy is ignored and not queued.
    cyc(1'b1, 1'b0, a, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, a, 1'b1);
    cyc(1'b1, 1'b0, b, 1'b1);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, b, 1'b1);
    check("no_queued_frame", {31'd0, valid2}, 32'd0);

    // Auto mode: a word change in idle starts one frame, a steady word starts none.
    cyc(1'b0, 1'b1, b, 1'b1);
    for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1, b, 1'b1);
    check("auto_single_frame", {31'd0, busy2}, 32'd0);

    // Auto change during busy fires after returning to idle; load plus auto gives one frame.
    cyc(1'b1, 1'b1, a, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, a, 1'b1);
    cyc(1'b0, 1'b1, b, 1'b1);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, b, 1'b1);

    // Reset mid-frame at bit 6 aborts without done; next load starts fresh.
    cyc(1'b1, 1'b0, a, 1'b1);
    for (int i = 0; i < 20 && m2.sent != 6; i++) cyc(1'b0, 1'b0, a, 1'b1);
    check("pre_reset_cnt6", {28'd0, cnt2}, 32'd6);
    pulse_reset();
    cyc(1'b1, 1'b0, b, 1'b1);
    check("fresh_cnt0", {28'd0, cnt2}, 32'd0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, b, 1'b1);

    // Back-to-back loads: the GAP=0 instance restarts right after done.
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, a, 1'b1);

    // Randomized traffic.
    rs = a;
    ra = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) rs = W'($urandom);
      if ($urandom_range(0, 39) == 0) ra = ~ra;
      cyc(($urandom_range(0, 7) == 0), ra, rs, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
